// File: rtl/alu_pkg.sv
// Shared op-codes, FSM encodings and flag bit positions for the sequential ALU.
package alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_PASS = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between register file, ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, flag_n, flag_v
  );
  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/alu_comb_nbit.sv
// Single-cycle combinational datapath for ops 000-110; op 111 yields zero here.
module alu_comb_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v
);
  logic [WIDTH-1:0] bop;
  logic [WIDTH:0]   sum;
  logic             arith;

  // Arithmetic ops share one adder; only the second input differs.
  always_comb begin
    bop = '0;
    case (op)
      OP_ADD:  bop = b;
      OP_SUB:  bop = ~b;
      OP_PASS: bop = '0;
      OP_DEC:  bop = '1;
      default: bop = '0;
    endcase
  end

  assign sum   = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
  assign arith = ~op[2];

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MUL:  res = '0;
      default: res = sum[WIDTH-1:0];
    endcase
  end

  assign c = arith & sum[WIDTH];
  assign v = arith & (a[WIDTH-1] == bop[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_seq.sv
// Registered ALU: valid/ready handshake, result/flag registers and a
// shift-add multiplier iterating one bit per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [0:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   res_lo_q;
  logic [WIDTH-1:0]   res_hi_q;
  logic [3:0]         flags_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               accept;
  logic               consume;
  logic [WIDTH-1:0]   prod_hi;
  logic [WIDTH-1:0]   prod_lo;

  alu_comb_nbit #(.WIDTH(WIDTH)) u_comb (
    .op  (bus.op),
    .a   (bus.a),
    .b   (bus.b),
    .cin (bus.cin),
    .res (alu_res),
    .c   (alu_c),
    .v   (alu_v)
  );

  assign bus.in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = out_valid_q && bus.out_ready;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign prod_hi = acc_nxt[2*WIDTH-1:WIDTH];
  assign prod_lo = acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      count       <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // A later set in this block wins, giving back-to-back overwrite.
      if (consume) out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              acc    <= '0;
              count  <= CW'(WIDTH);
              state  <= ST_BUSY;
            end else begin
              res_lo_q        <= alu_res;
              res_hi_q        <= '0;
              flags_q[FLAG_C] <= alu_c;
              flags_q[FLAG_V] <= alu_v;
              flags_q[FLAG_Z] <= (alu_res == '0);
              flags_q[FLAG_N] <= alu_res[WIDTH-1];
              out_valid_q     <= 1'b1;
            end
          end
        end
        default: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            res_lo_q        <= prod_lo;
            res_hi_q        <= prod_hi;
            flags_q[FLAG_C] <= (prod_hi != '0);
            flags_q[FLAG_V] <= (prod_hi != '0);
            flags_q[FLAG_Z] <= (acc_nxt == '0);
            flags_q[FLAG_N] <= prod_hi[WIDTH-1];
            out_valid_q     <= 1'b1;
            state           <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.flag_c    = flags_q[FLAG_C];
  assign bus.flag_z    = flags_q[FLAG_Z];
  assign bus.flag_n    = flags_q[FLAG_N];
  assign bus.flag_v    = flags_q[FLAG_V];
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq at WIDTH=4 and WIDTH=8.
module tb_alu_seq;
  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] f;   // {v,n,z,c}
  } exp_t;

  logic clk = 1'b0;
  logic rst4, rst8;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(4)) if4 ();
  alu_seq_if #(.WIDTH(8)) if8 ();

  alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));
  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));

  wire [3:0] f4 = {if4.flag_v, if4.flag_n, if4.flag_z, if4.flag_c};
  wire [3:0] f8 = {if8.flag_v, if8.flag_n, if8.flag_z, if8.flag_c};

  function automatic exp_t model(int w, logic [2:0] op, logic [7:0] a, logic [7:0] b, logic cin);
    longint m, half, ua, ub, bop, s, sa, sb, ss, lo, hi;
    logic c, v, n, z;
    exp_t e;
    m = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    lo = 0; hi = 0; c = 0; v = 0; bop = 0;
    if (op < 3'd4) begin
      case (op)
        3'd0: bop = ub;
        3'd1: bop = (~ub) & m;
        3'd2: bop = 0;
        default: bop = m;
      endcase
      s  = ua + bop + longint'(cin);
      lo = s & m;
      c  = (s > m);
      sa = (ua >= half) ? ua - (m + 1) : ua;
      sb = (bop >= half) ? bop - (m + 1) : bop;
      ss = sa + sb + longint'(cin);
      v  = (ss >= half) || (ss < -half);
    end else if (op == 3'd7) begin
      s  = ua * ub;
      lo = s & m;
      hi = s >> w;
      c  = (hi != 0);
      v  = c;
    end else begin
      case (op)
        3'd4: lo = ua & ub;
        3'd5: lo = ua | ub;
        default: lo = ua ^ ub;
      endcase
    end
    n = (op == 3'd7) ? (hi >= half) : (lo >= half);
    z = (lo == 0) && (hi == 0);
    e.lo = 8'(lo);
    e.hi = 8'(hi);
    e.f  = {v, n, z, c};
    return e;
  endfunction

  // Consume is decided at the next rising edge; out_ready only moves after edges.
  always @(negedge clk) begin
    exp_t e;
    if (!rst4 && if4.out_valid && if4.out_ready) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL sb4_unexpected: got lo=%h hi=%h f=%b, required no output", if4.res_lo, if4.res_hi, f4);
      end else begin
        e = q4.pop_front();
        if ({4'h0, if4.res_lo} !== e.lo || {4'h0, if4.res_hi} !== e.hi || f4 !== e.f) begin
          n_bad++;
          $display("FAIL sb4_result: got lo=%h hi=%h f=%b, required lo=%h hi=%h f=%b",
                   if4.res_lo, if4.res_hi, f4, e.lo[3:0], e.hi[3:0], e.f);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst8 && if8.out_valid && if8.out_ready) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_bad++;
        $display("FAIL sb8_unexpected: got lo=%h hi=%h f=%b, required no output", if8.res_lo, if8.res_hi, f8);
      end else begin
        e = q8.pop_front();
        if (if8.res_lo !== e.lo || if8.res_hi !== e.hi || f8 !== e.f) begin
          n_bad++;
          $display("FAIL sb8_result: got lo=%h hi=%h f=%b, required lo=%h hi=%h f=%b",
                   if8.res_lo, if8.res_hi, f8, e.lo, e.hi, e.f);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic cin);
    bit done = 0;
    if4.op = op; if4.a = a; if4.b = b; if4.cin = cin; if4.in_valid = 1'b1;
    q4.push_back(model(4, op, {4'h0, a}, {4'h0, b}, cin));
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (if4.in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if4.in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send4_timeout: got in_ready=0 for 50 cycles, required accept");
    end
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    bit done = 0;
    if8.op = op; if8.a = a; if8.b = b; if8.cin = cin; if8.in_valid = 1'b1;
    q8.push_back(model(8, op, a, b, cin));
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (if8.in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if8.in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send8_timeout: got in_ready=0 for 50 cycles, required accept");
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst8 = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if4.out_valid, if4.in_ready, if4.res_lo, if4.res_hi, f4} !== {1'b0, 1'b1, 4'h0, 4'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset4: got ov=%b ir=%b lo=%h hi=%h f=%b, required ov=0 ir=1 lo=0 hi=0 f=0000",
               if4.out_valid, if4.in_ready, if4.res_lo, if4.res_hi, f4);
    end
    n_cmp++;
    if ({if8.out_valid, if8.in_ready, if8.res_lo, if8.res_hi, f8} !== {1'b0, 1'b1, 8'h0, 8'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset8: got ov=%b ir=%b lo=%h hi=%h f=%b, required ov=0 ir=1 lo=0 hi=0 f=0000",
               if8.out_valid, if8.in_ready, if8.res_lo, if8.res_hi, f8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    if4.out_ready = 1'b1;
    send4(3'b000, 4'h7, 4'h9, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (if4.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL add_latency: got out_valid=%b, required 1", if4.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    send4(3'b001, 4'h3, 4'h5, 1'b1);
    send4(3'b001, 4'h7, 4'hF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    send4(3'b111, 4'hF, 4'hF, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if4.in_ready !== 1'b0 || if4.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_busy%0d: got in_ready=%b out_valid=%b, required 0 0", k, if4.in_ready, if4.out_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (if4.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_latency: got out_valid=%b at cycle 5, required 1", if4.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    if4.out_ready = 1'b0;
    send4(3'b100, 4'hC, 4'hA, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if4.out_valid !== 1'b1 || if4.res_lo !== 4'h8 || if4.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall%0d: got ov=%b lo=%h ir=%b, required ov=1 lo=8 ir=0", k, if4.out_valid, if4.res_lo, if4.in_ready);
      end
    end
    @(posedge clk); #1;
    if4.out_ready = 1'b1;
    send4(3'b101, 4'h3, 4'h4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_mul();
    send4(3'b111, 4'h5, 4'h3, 1'b0);
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    q4.delete();
    @(negedge clk);
    n_cmp++;
    if ({if4.out_valid, if4.in_ready, if4.res_lo, if4.res_hi} !== {1'b0, 1'b1, 4'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: got ov=%b ir=%b lo=%h hi=%h, required ov=0 ir=1 lo=0 hi=0",
               if4.out_valid, if4.in_ready, if4.res_lo, if4.res_hi);
    end
    @(posedge clk); #1;
    send4(3'b000, 4'h1, 4'h1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    if8.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if8.op = 3'b110; if8.a = a; if8.b = b; if8.cin = 1'b0; if8.in_valid = 1'b1;
      q8.push_back(model(8, 3'b110, a, b, 1'b0));
      @(negedge clk);
      n_cmp++;
      if (if8.in_ready !== 1'b1 || (i > 0 && if8.out_valid !== 1'b1)) begin
        n_bad++;
        $display("FAIL b2b%0d: got in_ready=%b out_valid=%b, required 1 1", i, if8.in_ready, if8.out_valid);
      end
      @(posedge clk); #1;
    end
    if8.in_valid = 1'b0;
    send8(3'b011, 8'h00, 8'h5A, 1'b0);
    send8(3'b010, 8'h7F, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    if4.in_valid = 1'b0; if4.op = '0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.op = '0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    n_cmp++;
    if (q4.size() != 0 || q8.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d results outstanding, required 0/0", q4.size(), q8.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
